// File: rtl/draw_pkg.sv
// Shared definitions for the frame draw scheduler.
// Holds the FSM state codes, the grant codes and the screen field widths.
package draw_pkg;
   localparam int X_W = 8;
   localparam int Y_W = 7;
   localparam int C_W = 3;

   typedef enum logic [2:0] {
      S_WAIT_GO = 3'd0,
      S_IDLE    = 3'd1,
      S_BG      = 3'd2,
      S_WALL    = 3'd3,
      S_BIRD    = 3'd4,
      S_UPDATE  = 3'd5,
      S_OVER    = 3'd6
   } state_t;

   localparam logic [2:0] GRANT_NONE = 3'b000;
   localparam logic [2:0] GRANT_BG   = 3'b001;
   localparam logic [2:0] GRANT_WALL = 3'b010;
   localparam logic [2:0] GRANT_BIRD = 3'b100;

   typedef struct packed {
      logic [X_W-1:0] x;
      logic [Y_W-1:0] y;
      logic [C_W-1:0] colour;
      logic           plot;
   } plot_req_t;

   function automatic logic [2:0] grant_of(input state_t s);
      case (s)
         S_BG:    return GRANT_BG;
         S_WALL:  return GRANT_WALL;
         S_BIRD:  return GRANT_BIRD;
         default: return GRANT_NONE;
      endcase
   endfunction
endpackage

// File: rtl/plot_mux.sv
// Plot port multiplexer: forwards the granted requester's pixel write.
// With no grant bit set the port reads as all zeros.
module plot_mux
   import draw_pkg::*;
(
   input  logic [2:0]      i_grant,
   input  plot_req_t [2:0] i_req,
   output plot_req_t       o_port
);
   plot_req_t [2:0] w_masked;

   // Grant is one-hot, so an AND-OR tree suffices
   for (genvar gi = 0; gi < 3; gi++) begin : g_mask
      assign w_masked[gi] = i_grant[gi] ? i_req[gi] : '0;
   end

   assign o_port = w_masked[0] | w_masked[1] | w_masked[2];
endmodule

// File: rtl/draw_scheduler.sv
// Frame scheduler: sequences background, wall and bird drawing passes on a
// shared plot port, then issues the position update or enters game over.
module draw_scheduler
   import draw_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 32767
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           go,
   input  logic           frame_tick,
   input  logic           collision,
   input  logic           bg_done,
   input  logic           wall_done,
   input  logic           bird_done,
   input  logic           bg_plot,
   input  logic           wall_plot,
   input  logic           bird_plot,
   input  logic [X_W-1:0] bg_x,
   input  logic [X_W-1:0] wall_x,
   input  logic [X_W-1:0] bird_x,
   input  logic [Y_W-1:0] bg_y,
   input  logic [Y_W-1:0] wall_y,
   input  logic [Y_W-1:0] bird_y,
   input  logic [C_W-1:0] bg_colour,
   input  logic [C_W-1:0] wall_colour,
   input  logic [C_W-1:0] bird_colour,
   output logic [2:0]     grant,
   output logic [X_W-1:0] vga_x,
   output logic [Y_W-1:0] vga_y,
   output logic [C_W-1:0] vga_colour,
   output logic           vga_plot,
   output logic           update_en,
   output logic           restart,
   output logic           game_over,
   output logic           frame_overrun,
   output logic           timeout_err,
   output logic [2:0]     cur_state
);
   localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   state_t           r_state;
   state_t           w_state_next;
   logic [CNT_W-1:0] r_cnt;
   logic [2:0]       r_grant;
   logic             r_coll, w_coll_next;
   logic             r_go_prev, r_update_en, r_restart, r_game_over;
   logic             r_frame_overrun, r_timeout_err;
   logic             w_in_draw, w_in_frame, w_done, w_timeout, w_advance, w_go_rise;
   plot_req_t [2:0]  w_req;
   plot_req_t        w_port;

   always_comb begin
      w_in_draw  = (r_state == S_BG) || (r_state == S_WALL) || (r_state == S_BIRD);
      w_in_frame = w_in_draw || (r_state == S_UPDATE);
      w_go_rise  = go && !r_go_prev;
      case (r_state)
         S_BG:    w_done = bg_done;
         S_WALL:  w_done = wall_done;
         S_BIRD:  w_done = bird_done;
         default: w_done = 1'b0;
      endcase
      w_timeout = w_in_draw && (r_cnt == CNT_LAST);
      w_advance = w_in_draw && (w_done || w_timeout);

      w_state_next = r_state;
      case (r_state)
         S_WAIT_GO: if (go)         w_state_next = S_IDLE;
         S_IDLE:    if (frame_tick) w_state_next = S_BG;
         S_BG:      if (w_advance)  w_state_next = S_WALL;
         S_WALL:    if (w_advance)  w_state_next = S_BIRD;
         S_BIRD:    if (w_advance)  w_state_next = S_UPDATE;
         S_UPDATE:  w_state_next = r_coll ? S_OVER : S_IDLE;
         S_OVER:    if (w_go_rise)  w_state_next = S_IDLE;
         default:   w_state_next = S_WAIT_GO;
      endcase

      w_coll_next = r_coll;
      if ((r_state == S_OVER) && (w_state_next != S_OVER)) begin
         w_coll_next = 1'b0;
      end else if (w_in_frame && collision) begin
         w_coll_next = 1'b1;
      end
   end

   // Outputs are registered from the next state so they line up with r_state
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state         <= S_WAIT_GO;
         r_grant         <= GRANT_NONE;
         r_cnt           <= '0;
         r_coll          <= 1'b0;
         r_go_prev       <= 1'b0;
         r_update_en     <= 1'b0;
         r_restart       <= 1'b0;
         r_game_over     <= 1'b0;
         r_frame_overrun <= 1'b0;
         r_timeout_err   <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_grant     <= grant_of(w_state_next);
         r_cnt       <= (w_in_draw && !w_advance) ? r_cnt + 1'b1 : '0;
         r_coll      <= w_coll_next;
         r_go_prev   <= go;
         r_update_en <= (w_state_next == S_UPDATE) && !w_coll_next;
         r_restart   <= ((r_state == S_WAIT_GO) && go) || ((r_state == S_OVER) && w_go_rise);
         r_game_over <= (w_state_next == S_OVER);
         if (w_in_frame && frame_tick) r_frame_overrun <= 1'b1;
         if (w_timeout && !w_done)     r_timeout_err   <= 1'b1;
      end
   end

   assign w_req[0] = '{x: bg_x,   y: bg_y,   colour: bg_colour,   plot: bg_plot};
   assign w_req[1] = '{x: wall_x, y: wall_y, colour: wall_colour, plot: wall_plot};
   assign w_req[2] = '{x: bird_x, y: bird_y, colour: bird_colour, plot: bird_plot};

   plot_mux u_plot_mux (
      .i_grant (r_grant),
      .i_req   (w_req),
      .o_port  (w_port)
   );

   assign grant         = r_grant;
   assign vga_x         = w_port.x;
   assign vga_y         = w_port.y;
   assign vga_colour    = w_port.colour;
   assign vga_plot      = w_port.plot;
   assign update_en     = r_update_en;
   assign restart       = r_restart;
   assign game_over     = r_game_over;
   assign frame_overrun = r_frame_overrun;
   assign timeout_err   = r_timeout_err;
   assign cur_state     = r_state;
endmodule

// File: doc/draw_scheduler.md
DRAW_SCHEDULER -- requirements
Module: draw_scheduler

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 32767, maximum cycles a draw phase may hold the plot port before forced advance.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 go  input  1  player key level; starts the game and restarts it after game over.
REQ-005 frame_tick  input  1  one-cycle pulse per display frame.
REQ-006 collision  input  1  bird/wall overlap indication, sampled every cycle.
REQ-007 bg_done, wall_done, bird_done  input  1 each  one-cycle pulse when that requester finishes its drawing pass.
REQ-008 bg_plot, wall_plot, bird_plot  input  1 each  requester pixel-write strobe.
REQ-009 bg_x, wall_x, bird_x  input  8 each  requester pixel column (0-159).
REQ-010 bg_y, wall_y, bird_y  input  7 each  requester pixel row (0-119).
REQ-011 bg_colour, wall_colour, bird_colour  input  3 each  requester pixel colour.
REQ-012 grant  output  3  one-hot owner of the plot port: bit0 bg, bit1 wall, bit2 bird; 000 when none.
REQ-013 vga_x, vga_y, vga_colour, vga_plot  output  8/7/3/1  muxed plot port to the VGA adapter.
REQ-014 update_en  output  1  one-cycle pulse telling bird and wall controllers to advance positions.
REQ-015 restart  output  1  one-cycle pulse telling game controllers to reload initial positions.
REQ-016 game_over  output  1  high while in S_OVER.
REQ-017 frame_overrun, timeout_err  output  1 each  sticky error flags.
REQ-018 cur_state  output  3  current state encoding.

Function
REQ-019 States: S_WAIT_GO, S_IDLE, S_BG, S_WALL, S_BIRD, S_UPDATE, S_OVER.
REQ-020 S_WAIT_GO -> S_IDLE when go=1; restart pulses in that transition cycle.
REQ-021 S_IDLE -> S_BG on frame_tick=1; otherwise hold.
REQ-022 S_BG -> S_WALL, S_WALL -> S_BIRD, S_BIRD -> S_UPDATE on the owning requester's done pulse or on timeout.
REQ-023 S_UPDATE lasts exactly one cycle with update_en=1, then -> S_IDLE, or -> S_OVER if the collision latch is set (update_en still 0 in that case).
REQ-024 Collision latch sets on any cycle with collision=1 while in S_BG..S_UPDATE; cleared on leaving S_OVER and on reset.
REQ-025 S_OVER: grant=000, game_over=1; -> S_IDLE with restart=1 when go rises (0-to-1 edge, not level).
REQ-026 grant is a registered function of state: S_BG 001, S_WALL 010, S_BIRD 100, all other states 000.
REQ-027 vga_x/y/colour/plot combinationally select the granted requester's signals; with grant=000 vga_plot=0 and other vga outputs 0.
REQ-028 done and plot from non-granted requesters are ignored.
REQ-029 Phase counter clears on entering each draw state and increments each cycle in it; reaching TIMEOUT_CYCLES-1 without done forces advance next cycle and sets timeout_err.
REQ-030 Done arriving in the same cycle as timeout is treated as done; timeout_err not set.
REQ-031 frame_tick in any state other than S_IDLE is dropped and sets frame_overrun (except S_WAIT_GO and S_OVER, where it is silently ignored).
REQ-032 Counter width is ceil(log2(TIMEOUT_CYCLES)); no wrap occurs because the forced advance clears it.

Reset
REQ-033 On reset: state S_WAIT_GO, grant 000, vga_plot 0, vga_x/y/colour 0, update_en 0, restart 0, game_over 0, collision latch 0, counter 0, frame_overrun 0, timeout_err 0.
REQ-034 Reset mid-frame abandons the phase immediately; no done/update pulse is generated afterwards.

Structure
REQ-035 State encodings, grant one-hot constants and screen widths (8/7/3) live in shared package draw_pkg.
REQ-036 Output mux is a separate sub-module plot_mux (3 requesters, grant-selected); FSM, latch and counter in draw_scheduler.

Verification
REQ-037 Reset, go=1 one cycle, frame_tick -> grant 001; bg_done -> 010; wall_done -> 100; bird_done -> one-cycle update_en then cur_state S_IDLE.
REQ-038 In S_WALL drive bird_plot=1, bird_x=50 -> vga_plot=0; wall_plot=1, wall_x=20 -> vga_x=20, vga_plot=1.
REQ-039 TIMEOUT_CYCLES=16, never assert bg_done -> grant moves 001->010 after 16 cycles, timeout_err=1 sticky.
REQ-040 collision=1 one cycle during S_BG -> frame completes, no update_en, game_over=1; go edge -> restart pulse, S_IDLE.
REQ-041 frame_tick during S_BIRD -> frame_overrun=1, no extra frame started after S_UPDATE.
REQ-042 Async reset asserted mid S_WALL between clock edges -> grant 000 and vga_plot 0 immediately, state S_WAIT_GO.
